// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and widths for the LED waveform blocks
package led_pkg;

  localparam int THR_W = 9;
  localparam int RST_W = 16;

  localparam logic [THR_W-1:0] HIGH_MAX = '1;
  localparam logic [RST_W-1:0] LOW_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STALL = 2'd3
  } dec_state_t;

endpackage

// File: rtl/waveform_dec_if.sv
// rtl/waveform_dec_if.sv - decoded byte / frame event bundle
interface waveform_dec_if;

  logic       byte_vld_o;
  logic [7:0] byte_data_o;
  logic       frame_end_o;
  logic       err_o;

  modport master (
    output byte_vld_o,
    output byte_data_o,
    output frame_end_o,
    output err_o
  );

  modport slave (
    input byte_vld_o,
    input byte_data_o,
    input frame_end_o,
    input err_o
  );

endinterface

// File: rtl/line_sync.sv
// rtl/line_sync.sv - 2-flop synchronizer for an asynchronous pad input
module line_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/waveform_dec.sv
// rtl/waveform_dec.sv - single-wire pulse-width decoder to MSB-first bytes
module waveform_dec
  import led_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             bit_code_i,
  input  logic [THR_W-1:0] reg_thr_time_i,
  input  logic [RST_W-1:0] reg_rst_time_i,
  waveform_dec_if.master   dec_if
);

  logic             line_s;
  logic             line_d;
  logic             rise;
  logic             fall;
  logic [THR_W-1:0] high_cnt;
  logic [RST_W-1:0] low_cnt;

  dec_state_t state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  // Only the 7 pending bits are kept; the 8th lands directly in the output byte.
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_vld_q, byte_vld_d;
  logic       frame_end_q, frame_end_d;
  logic       err_q, err_d;
  logic       bit_val;

  line_sync u_line_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (bit_code_i),
    .sync_o  (line_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) line_d <= 1'b0;
    else          line_d <= line_s;
  end

  assign rise = line_s & ~line_d;
  assign fall = ~line_s & line_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                         high_cnt <= '0;
    else if (rise)                        high_cnt <= THR_W'(1);
    else if (line_s && high_cnt != HIGH_MAX) high_cnt <= high_cnt + THR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                  low_cnt <= '0;
    else if (line_s)               low_cnt <= '0;
    else if (fall)                 low_cnt <= RST_W'(1);
    else if (low_cnt != LOW_MAX)   low_cnt <= low_cnt + RST_W'(1);
  end

  assign bit_val = (high_cnt > reg_thr_time_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      byte_data_q <= '0;
      byte_vld_q  <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      byte_data_q <= byte_data_d;
      byte_vld_q  <= byte_vld_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    byte_data_d = byte_data_q;
    byte_vld_d  = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          shreg_d   = {shreg_q[5:0], bit_val};
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = LOW;
          if (bit_idx_q == 3'd7) begin
            byte_data_d = {shreg_q, bit_val};
            byte_vld_d  = 1'b1;
          end
        end else if (line_s && high_cnt == HIGH_MAX) begin
          err_d     = 1'b1;
          bit_idx_d = '0;
          state_d   = STALL;
        end
      end
      STALL: begin
        if (fall) state_d = LOW;
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (low_cnt == reg_rst_time_i) begin
          frame_end_d = 1'b1;
          err_d       = (bit_idx_q != 3'd0);
          bit_idx_d   = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dec_if.byte_vld_o  = byte_vld_q;
  assign dec_if.byte_data_o = byte_data_q;
  assign dec_if.frame_end_o = frame_end_q;
  assign dec_if.err_o       = err_q;

endmodule

// File: tb/tb_waveform_dec.sv
// tb/tb_waveform_dec.sv - directed self-checking bench for waveform_dec
module tb_waveform_dec;
  import led_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             bit_code_i;
  logic [THR_W-1:0] reg_thr_time_i;
  logic [RST_W-1:0] reg_rst_time_i;

  waveform_dec_if dec_if ();

  waveform_dec dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .bit_code_i     (bit_code_i),
    .reg_thr_time_i (reg_thr_time_i),
    .reg_rst_time_i (reg_rst_time_i),
    .dec_if         (dec_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int last_fall = 0;
  logic [7:0] byte_q [$];
  int vld_cyc, fe_cyc, err_cyc;
  int fe_cnt, err_cnt, fe_err, both_cnt;

  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (dec_if.byte_vld_o) begin
      byte_q.push_back(dec_if.byte_data_o);
      vld_cyc = cyc;
    end
    if (dec_if.frame_end_o) begin
      fe_cnt++;
      fe_cyc = cyc;
      fe_err = int'(dec_if.err_o);
    end
    if (dec_if.err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (dec_if.byte_vld_o && dec_if.frame_end_o) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qget(input int i);
    if (byte_q.size() > i) return byte_q[i];
    return 8'hxx;
  endfunction

  task automatic clear_mon();
    byte_q.delete();
    vld_cyc  = -1;
    fe_cyc   = -1;
    err_cyc  = -1;
    fe_cnt   = 0;
    err_cnt  = 0;
    fe_err   = 0;
    both_cnt = 0;
  endtask

  // Called at a negedge; line high for hi clocks then low for lo clocks.
  task automatic send_bit(input int hi, input int lo);
    bit_code_i = 1'b1;
    last_rise  = cyc;
    repeat (hi) @(negedge clk_i);
    bit_code_i = 1'b0;
    last_fall  = cyc;
    repeat (lo) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i] ? 30 : 10, 10);
  endtask

  task automatic hold_low(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_n_i        = 1'b0;
    bit_code_i     = 1'b0;
    reg_thr_time_i = 9'd20;
    reg_rst_time_i = 16'd100;
    clear_mon();
    repeat (3) @(negedge clk_i);
    check("rst_vld",  {31'd0, dec_if.byte_vld_o},  32'd0);
    check("rst_data", {24'd0, dec_if.byte_data_o}, 32'd0);
    check("rst_fe",   {31'd0, dec_if.frame_end_o}, 32'd0);
    check("rst_err",  {31'd0, dec_if.err_o},       32'd0);
    rst_n_i = 1'b1;
    hold_low(5);

    // 0xAA with 30/10 high times
    clear_mon();
    send_byte(8'hAA);
    check("aa_count", byte_q.size(), 1);
    check("aa_data",  {24'd0, qget(0)}, 32'hAA);
    check("aa_lat",   vld_cyc - last_fall, 3);
    hold_low(100);
    check("aa_fe",    fe_cnt, 1);
    check("aa_hold",  {24'd0, dec_if.byte_data_o}, 32'hAA);

    // three bytes then frame reset
    clear_mon();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h5A);
    hold_low(100);
    check("b3_count", byte_q.size(), 3);
    check("b3_d0",    {24'd0, qget(0)}, 32'hFF);
    check("b3_d1",    {24'd0, qget(1)}, 32'h00);
    check("b3_d2",    {24'd0, qget(2)}, 32'h5A);
    check("b3_fe",    fe_cnt, 1);
    check("b3_fe_lat", fe_cyc - last_fall, 103);
    check("b3_fe_err", fe_err, 0);
    check("b3_err",   err_cnt, 0);
    check("b3_excl",  both_cnt, 0);

    // threshold boundary: 20 -> 0, 21 -> 1
    clear_mon();
    for (int i = 0; i < 7; i++) send_bit(20, 10);
    send_bit(21, 10);
    hold_low(100);
    check("thr_data", {24'd0, qget(0)}, 32'h01);
    check("thr_fe",   fe_cnt, 1);

    // partial byte then frame reset
    clear_mon();
    for (int i = 0; i < 5; i++) send_bit(30, 10);
    hold_low(100);
    check("part_vld",   byte_q.size(), 0);
    check("part_fe",    fe_cnt, 1);
    check("part_fe_err", fe_err, 1);
    check("part_err",   err_cnt, 1);
    clear_mon();
    send_byte(8'h96);
    hold_low(100);
    check("part_next", {24'd0, qget(0)}, 32'h96);
    check("part_next_err", err_cnt, 0);

    // long high: overflow error, then clean byte
    clear_mon();
    send_bit(600, 10);
    check("ovf_err",   err_cnt, 1);
    check("ovf_lat",   err_cyc - last_rise, 514);
    check("ovf_vld",   byte_q.size(), 0);
    send_byte(8'h3C);
    hold_low(100);
    check("ovf_count", byte_q.size(), 1);
    check("ovf_next",  {24'd0, qget(0)}, 32'h3C);
    check("ovf_fe_err", fe_err, 0);

    // reset mid-byte
    for (int i = 0; i < 4; i++) send_bit(30, 10);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check("mr_data", {24'd0, dec_if.byte_data_o}, 32'h00);
    check("mr_vld",  {31'd0, dec_if.byte_vld_o},  32'd0);
    check("mr_fe",   {31'd0, dec_if.frame_end_o}, 32'd0);
    check("mr_err",  {31'd0, dec_if.err_o},       32'd0);
    clear_mon();
    hold_low(150);
    check("mr_no_fe",  fe_cnt, 0);
    check("mr_no_err", err_cnt, 0);
    send_byte(8'hC3);
    hold_low(100);
    check("mr_next", {24'd0, qget(0)}, 32'hC3);
    check("mr_fe2",  fe_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_dec.md
# waveform_dec

Single-wire NeoPixel-style waveform decoder: the receive-side counterpart of the LED bit-waveform generator. It samples an asynchronous serial line and measures each high pulse against a programmable threshold to recover bits. It assembles the bits MSB-first into bytes and detects the long-low frame reset. It sits between the line input pad and a byte FIFO or loopback checker in the controller design.

## Interface
- No parameters; widths fixed below.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `bit_code_i` in 1: asynchronous serial line.
- `reg_thr_time_i` in 9: high-time threshold in clocks. Bit decodes as 1 when high time > threshold, else 0.
- `reg_rst_time_i` in 16: consecutive low clocks that signal a frame reset. Must be ≥1.
- `byte_vld_o` out 1: one-cycle strobe; `byte_data_o` is valid this cycle.
- `byte_data_o` out 8: last completed byte, first-received bit in bit 7. Held until the next strobe.
- `frame_end_o` out 1: one-cycle strobe when a frame reset is detected.
- `err_o` out 1: one-cycle strobe on a framing error.

## Operation
- **Synchronizer:** 2-flop synchronizer produces `line_s`; one further flop produces `line_d`.
  - rise = `line_s & ~line_d`
  - fall = `~line_s & line_d`
- **Counters:**
  - `high_cnt` (9 b, saturating at 511): loads 1 on rise, increments while `line_s`=1.
  - `low_cnt` (16 b, saturating): loads 1 on fall, increments while `line_s`=0, clears when `line_s`=1.
- **Bit index:** `bit_idx` (3 b) counts bits received into the shift register `shreg` (8 b).
- **FSM states:** IDLE, HIGH, LOW, STALL.
  - IDLE: not armed. On rise → HIGH. No frame_end is generated in IDLE.
  - HIGH, on fall:
    - decode `bit = high_cnt > reg_thr_time_i`;
    - shift `shreg = {shreg[6:0], bit}`;
    - `bit_idx+1`;
    - go to LOW.
    - If `bit_idx` was 7: register `byte_data_o = {shreg[6:0], bit}`, pulse `byte_vld_o`, `bit_idx` wraps to 0.
  - HIGH, on `high_cnt` reaching 511 with the line still high: pulse `err_o`, clear `bit_idx`, go to STALL.
  - STALL: on fall → LOW. No bit is shifted.
  - LOW, on rise: → HIGH.
  - LOW, on `low_cnt == reg_rst_time_i`:
    - pulse `frame_end_o`;
    - if `bit_idx != 0`, pulse `err_o` as well (partial byte) and clear `bit_idx`;
    - go to IDLE.
- **Exclusive events:** `byte_vld_o` and `frame_end_o` never assert in the same cycle. `err_o` may coincide with `frame_end_o`.
- **Register inputs:** sampled live. Software changes them only while no frame is in progress.
- **Reset:** on reset (any time, including mid-byte) the following clear to 0, and state → IDLE:
  - sync flops, counters, `shreg`, `bit_idx`;
  - all outputs, including `byte_data_o`.

## Timing
- All outputs are registered and reset to 0.
- Latency: the line edge captured by the first sync flop at clock edge k is decided at edge k+2. The resulting strobe is visible in the cycle after edge k+2.
- High time is measured in `line_s` cycles. A line held high N clocks gives `high_cnt`=N at the fall cycle.
- Frame end strobes exactly `reg_rst_time_i` low clocks after the fall (plus the same 2-cycle sync delay).
- Back-to-back bits need no gap beyond one low sample. Minimum decodable pulse: 1 clock high, 1 clock low.
- `low_cnt` saturates at 65535. If `reg_rst_time_i` is never reached, the FSM remains in LOW.

## Structure
- Shared package `led_pkg`: state enum `dec_state_t` {IDLE, HIGH, LOW, STALL} and width constants `THR_W`=9, `RST_W`=16.
- One sub-module, `line_sync`: 2-flop synchronizer with sync active-low reset, reusable for other pad inputs.

## Test plan
- Thr=20, rst=100; send 8 pulses high/low alternating 30/10 clocks → `byte_vld_o` once with `byte_data_o`=0xAA, exactly 3 clocks after the 8th falling edge.
- Same settings; send 3 bytes 0xFF,0x00,0x5A, then hold low 100 → three strobes in order. `frame_end_o` fires 100 clocks after the last fall, with `err_o`=0.
- Threshold boundary: high exactly 20 → bit 0; high 21 → bit 1. Verify over a byte 0x01.
- Send 5 bits, then hold low 100 → `frame_end_o` and `err_o` in the same cycle, no `byte_vld_o`. The next full byte decodes correctly.
- Hold line high 600 clocks → a single `err_o` when `high_cnt` hits 511. After the fall, no bit is shifted, and the following 8 bits produce the correct byte.
- Assert `rst_n_i` for 1 clock after 4 bits → all outputs 0 next cycle. The line held low ≥ rst produces no `frame_end_o` (IDLE not armed).
